// File: rtl/npu_mem_pkg.sv
// npu_mem_pkg: shared types, default sizes and word-index helper for the NPU scratch memory.
package npu_mem_pkg;
  typedef enum logic [1:0] {IDLE, CLEAR, DONE} clr_state_e;
  localparam int WORD_W_DEF = 24;
  localparam int LANES_DEF  = 3;
  localparam int DEPTH_DEF  = 18;
  function automatic int word_idx(input int row, input int lane, input int lanes);
    return row * lanes + lane;
  endfunction
endpackage

// File: rtl/npu_mem_clear_ctrl.sv
// npu_mem_clear_ctrl: background clear FSM that zeroes the array one row per cycle.
module npu_mem_clear_ctrl
  import npu_mem_pkg::*;
#(
  parameter int ROWS = 6,
  parameter int RW   = 3
) (
  input  logic          clk_i,
  input  logic          reset_i,
  input  logic          clr_start_i,
  output logic          clear_we_o,
  output logic [RW-1:0] clear_row_o,
  output logic          clr_busy_o,
  output logic          clr_done_o,
  output logic          port_block_o
);
  clr_state_e    state_q, state_d;
  logic [RW-1:0] row_q, row_d;
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      state_q <= IDLE;
      row_q   <= '0;
    end else begin
      state_q <= state_d;
      row_q   <= row_d;
    end
  end
  always_comb begin
    state_d = state_q;
    row_d   = row_q;
    case (state_q)
      IDLE: begin
        state_d = clr_start_i ? CLEAR : IDLE;
        row_d   = clr_start_i ? '0 : row_q;
      end
      CLEAR: begin
        state_d = (row_q == RW'(ROWS - 1)) ? DONE : CLEAR;
        row_d   = (row_q == RW'(ROWS - 1)) ? row_q : row_q + RW'(1);
      end
      default: state_d = IDLE;
    endcase
  end
  assign clear_we_o   = state_q == CLEAR;
  assign clear_row_o  = row_q;
  assign clr_busy_o   = state_q == CLEAR;
  assign clr_done_o   = state_q == DONE;
  assign port_block_o = state_q == CLEAR;
endmodule

// File: rtl/npu_scratch_mem.sv
// npu_scratch_mem: dual-view scratch memory (scalar word port + NPU row port) with background clear.
module npu_scratch_mem
  import npu_mem_pkg::*;
#(
  parameter int WORD_W   = WORD_W_DEF,
  parameter int LANES    = LANES_DEF,
  parameter int DEPTH    = DEPTH_DEF,
  localparam int ROWS    = DEPTH / LANES,
  localparam int AW      = (DEPTH > 1) ? $clog2(DEPTH) : 1,
  localparam int RW      = (ROWS > 1) ? $clog2(ROWS) : 1
) (
  input  logic                    clk_i,
  input  logic                    reset_i,
  input  logic                    s_rd_en_i,
  input  logic                    s_wr_en_i,
  input  logic [AW-1:0]           s_addr_i,
  input  logic [WORD_W-1:0]       s_wdata_i,
  output logic [WORD_W-1:0]       s_rdata_o,
  output logic                    s_rvalid_o,
  output logic                    s_err_o,
  input  logic                    n_rd_en_i,
  input  logic                    n_wr_en_i,
  input  logic [RW-1:0]           n_addr_i,
  input  logic [LANES*WORD_W-1:0] n_wdata_i,
  output logic [LANES*WORD_W-1:0] n_rdata_o,
  output logic                    n_rvalid_o,
  output logic                    n_err_o,
  input  logic                    clr_start_i,
  output logic                    clr_busy_o,
  output logic                    clr_done_o
);
  if (DEPTH % LANES != 0) begin : g_depth_chk
    $error("DEPTH must be a multiple of LANES");
  end
  logic [WORD_W-1:0]       mem_q [DEPTH];
  logic [WORD_W-1:0]       mem_d [DEPTH];
  logic [WORD_W-1:0]       s_rdata_q, s_rdata_d;
  logic [LANES*WORD_W-1:0] n_rdata_q, n_rdata_d, n_row;
  logic                    s_rvalid_q, s_err_q, n_rvalid_q, n_err_q;
  logic                    blk, clear_we, s_ok, n_ok, s_we, n_we;
  logic [RW-1:0]           clear_row;
  npu_mem_clear_ctrl #(.ROWS(ROWS), .RW(RW)) u_clr (
    .clk_i        (clk_i),
    .reset_i      (reset_i),
    .clr_start_i  (clr_start_i),
    .clear_we_o   (clear_we),
    .clear_row_o  (clear_row),
    .clr_busy_o   (clr_busy_o),
    .clr_done_o   (clr_done_o),
    .port_block_o (blk)
  );
  assign s_ok = {1'b0, s_addr_i} < (AW + 1)'(DEPTH);
  assign n_ok = {1'b0, n_addr_i} < (RW + 1)'(ROWS);
  assign s_we = s_wr_en_i & s_ok & ~blk;
  assign n_we = n_wr_en_i & n_ok & ~blk;
  // NPU lanes are applied after the scalar word so the row write wins on collision
  always_comb begin
    mem_d = mem_q;
    for (int i = 0; i < DEPTH; i++) begin
      mem_d[i] = (s_we && s_addr_i == AW'(i)) ? s_wdata_i : mem_d[i];
      mem_d[i] = (n_we && n_addr_i == RW'(i / LANES)) ? n_wdata_i[(i % LANES)*WORD_W +: WORD_W] : mem_d[i];
      mem_d[i] = (clear_we && clear_row == RW'(i / LANES)) ? '0 : mem_d[i];
    end
  end
  always_comb begin
    n_row = '0;
    for (int k = 0; k < LANES; k++)
      n_row[k*WORD_W +: WORD_W] = mem_q[AW'(word_idx(int'(n_addr_i), k, LANES))];
  end
  assign s_rdata_d = s_rd_en_i ? ((s_ok && !blk) ? mem_q[s_addr_i] : '0) : s_rdata_q;
  assign n_rdata_d = n_rd_en_i ? ((n_ok && !blk) ? n_row : '0) : n_rdata_q;
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      mem_q      <= '{default: '0};
      s_rdata_q  <= '0;
      n_rdata_q  <= '0;
      s_rvalid_q <= 1'b0;
      s_err_q    <= 1'b0;
      n_rvalid_q <= 1'b0;
      n_err_q    <= 1'b0;
    end else begin
      mem_q      <= mem_d;
      s_rdata_q  <= s_rdata_d;
      n_rdata_q  <= n_rdata_d;
      s_rvalid_q <= s_rd_en_i;
      s_err_q    <= (s_rd_en_i | s_wr_en_i) & (blk | ~s_ok);
      n_rvalid_q <= n_rd_en_i;
      n_err_q    <= (n_rd_en_i | n_wr_en_i) & (blk | ~n_ok);
    end
  end
  assign s_rdata_o  = s_rdata_q;
  assign s_rvalid_o = s_rvalid_q;
  assign s_err_o    = s_err_q;
  assign n_rdata_o  = n_rdata_q;
  assign n_rvalid_o = n_rvalid_q;
  assign n_err_o    = n_err_q;
endmodule

// File: tb/tb_npu_scratch_mem.sv
// tb_npu_scratch_mem: directed self-checking bench for npu_scratch_mem at default sizes.
module tb_npu_scratch_mem;
  logic        clk = 1'b0, reset = 1'b1;
  logic        s_rd = 1'b0, s_wr = 1'b0, n_rd = 1'b0, n_wr = 1'b0, clr_start = 1'b0;
  logic [4:0]  s_addr = '0;
  logic [23:0] s_wdata = '0, s_rdata;
  logic [2:0]  n_addr = '0;
  logic [71:0] n_wdata = '0, n_rdata;
  logic        s_rvalid, s_err, n_rvalid, n_err, clr_busy, clr_done;
  int          checks = 0, passed = 0;

  npu_scratch_mem dut (
    .clk_i(clk), .reset_i(reset),
    .s_rd_en_i(s_rd), .s_wr_en_i(s_wr), .s_addr_i(s_addr), .s_wdata_i(s_wdata),
    .s_rdata_o(s_rdata), .s_rvalid_o(s_rvalid), .s_err_o(s_err),
    .n_rd_en_i(n_rd), .n_wr_en_i(n_wr), .n_addr_i(n_addr), .n_wdata_i(n_wdata),
    .n_rdata_o(n_rdata), .n_rvalid_o(n_rvalid), .n_err_o(n_err),
    .clr_start_i(clr_start), .clr_busy_o(clr_busy), .clr_done_o(clr_done)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [71:0] obs, input logic [71:0] exp);
    checks++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: got %h expected %h", tag, obs, exp);
  endtask

  function automatic logic [71:0] row_val(input int base, input int r);
    logic [71:0] v;
    for (int k = 0; k < 3; k++) v[k*24 +: 24] = 24'(base + 3 * r + k + 1);
    return v;
  endfunction

  task automatic fill(input int base);
    n_wr = 1'b1;
    for (int r = 0; r < 6; r++) begin
      n_addr = 3'(r);
      n_wdata = row_val(base, r);
      tick();
    end
    n_wr = 1'b0;
  endtask

  task automatic check_zero(input string tag);
    n_rd = 1'b1;
    for (int r = 0; r < 6; r++) begin
      n_addr = 3'(r);
      tick();
      chk($sformatf("%s_row%0d", tag, r), n_rdata, 72'h0);
    end
    n_rd = 1'b0;
  endtask

  task automatic run_clear(input string tag, input bit probe);
    int busy_n, done_n, done_at;
    busy_n = 0; done_n = 0; done_at = -1;
    clr_start = 1'b1;
    tick();
    clr_start = 1'b0;
    for (int k = 0; k < 10; k++) begin
      if (clr_busy) busy_n++;
      if (clr_done) begin done_n++; done_at = k; end
      if (probe && k == 0) begin s_rd = 1'b1; s_addr = 5'd17; end
      if (probe && k == 1) begin
        chk("clr_probe_err", 72'(s_err), 72'h1);
        chk("clr_probe_rvalid", 72'(s_rvalid), 72'h1);
        chk("clr_probe_rdata", 72'(s_rdata), 72'h0);
        s_rd = 1'b0;
      end
      clr_start = probe && k == 2;
      tick();
    end
    chk({tag, "_busy_cycles"}, 72'(busy_n), 72'd6);
    chk({tag, "_done_cycles"}, 72'(done_n), 72'd1);
    chk({tag, "_done_at"}, 72'(done_at), 72'd6);
  endtask

  initial begin
    tick(); tick();
    reset = 1'b0;
    chk("rst_s_rdata", 72'(s_rdata), 72'h0);
    chk("rst_s_rvalid", 72'(s_rvalid), 72'h0);
    chk("rst_n_rdata", n_rdata, 72'h0);
    chk("rst_busy_done", {70'h0, clr_busy, clr_done}, 72'h0);
    tick();
    s_rd = 1'b1; s_addr = 5'd5;
    tick();
    s_rd = 1'b0;
    chk("rd5_rdata", 72'(s_rdata), 72'h0);
    chk("rd5_rvalid", 72'(s_rvalid), 72'h1);
    chk("rd5_err", 72'(s_err), 72'h0);
    tick();
    chk("rd5_rvalid_pulse", 72'(s_rvalid), 72'h0);
    s_wr = 1'b1; s_addr = 5'd4; s_wdata = 24'hABCDEF;
    tick();
    s_wr = 1'b0; n_rd = 1'b1; n_addr = 3'd1;
    tick();
    n_rd = 1'b0;
    chk("xport_row1", n_rdata, 72'h000000_ABCDEF_000000);
    chk("xport_rvalid", 72'(n_rvalid), 72'h1);
    n_wr = 1'b1; n_addr = 3'd2; n_wdata = 72'h333333_222222_111111;
    s_wr = 1'b1; s_rd = 1'b1; s_addr = 5'd7; s_wdata = 24'h999999;
    tick();
    n_wr = 1'b0; s_wr = 1'b0;
    chk("coll_read_first", 72'(s_rdata), 72'h0);
    chk("coll_no_err", 72'(s_err), 72'h0);
    tick();
    chk("coll_addr7", 72'(s_rdata), 72'h222222);
    s_addr = 5'd6;
    tick();
    chk("coll_addr6", 72'(s_rdata), 72'h111111);
    s_addr = 5'd8;
    tick();
    chk("coll_addr8", 72'(s_rdata), 72'h333333);
    s_rd = 1'b0;
    s_wr = 1'b1; s_addr = 5'd18; s_wdata = 24'h123456; n_rd = 1'b1; n_addr = 3'd6;
    tick();
    s_wr = 1'b0; n_rd = 1'b0;
    chk("oor_s_err", 72'(s_err), 72'h1);
    chk("oor_n_err", 72'(n_err), 72'h1);
    chk("oor_n_rvalid", 72'(n_rvalid), 72'h1);
    chk("oor_n_rdata", n_rdata, 72'h0);
    chk("oor_s_rvalid", 72'(s_rvalid), 72'h0);
    n_rd = 1'b1; n_addr = 3'd0;
    tick();
    chk("oor_err_pulse", {70'h0, s_err, n_err}, 72'h0);
    chk("oor_row0", n_rdata, 72'h0);
    n_addr = 3'd1;
    tick();
    n_rd = 1'b0;
    chk("oor_row1", n_rdata, 72'h000000_ABCDEF_000000);
    fill(0);
    s_rd = 1'b1; s_addr = 5'd17;
    tick();
    s_rd = 1'b0;
    chk("fill_addr17", 72'(s_rdata), 72'h12);
    run_clear("clr1", 1'b1);
    check_zero("clr1_zero");
    fill(32'h100);
    s_rd = 1'b1; s_addr = 5'd17; n_rd = 1'b1; n_addr = 3'd5;
    tick();
    s_rd = 1'b0; n_rd = 1'b0;
    chk("refill_addr17", 72'(s_rdata), 72'h112);
    chk("refill_row5", n_rdata, 72'h000112_000111_000110);
    clr_start = 1'b1;
    tick();
    clr_start = 1'b0;
    tick(); tick(); tick();
    chk("mid_busy", 72'(clr_busy), 72'h1);
    reset = 1'b1;
    #1;
    chk("mid_rst_busy_done", {70'h0, clr_busy, clr_done}, 72'h0);
    chk("mid_rst_s_rdata", 72'(s_rdata), 72'h0);
    chk("mid_rst_n_rdata", n_rdata, 72'h0);
    tick(); tick();
    reset = 1'b0;
    begin
      int act_n;
      act_n = 0;
      for (int k = 0; k < 10; k++) begin
        if (clr_busy || clr_done) act_n++;
        tick();
      end
      chk("mid_rst_no_done", 72'(act_n), 72'h0);
    end
    check_zero("rst_zero");
    fill(32'h200);
    run_clear("clr2", 1'b0);
    check_zero("clr2_zero");
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end
endmodule

// File: doc/npu_scratch_mem.md
# npu_scratch_mem

Parametrised scratch memory shared by the scalar datapath and the NPU. Scalar port reads/writes one WORD_W word; NPU port reads/writes one row of LANES words. Adds registered read-valid handshakes on both ports, out-of-range and busy error reporting, a defined collision rule, and a background clear engine that zeroes the array row by row.

## Interface
- WORD_W, 24, bits per word
- LANES, 3, words per NPU row
- DEPTH, 18, total words; must be a multiple of LANES (elaboration error otherwise)
- ROWS, DEPTH/LANES, derived, not overridable
- AW, $clog2(DEPTH), scalar address width; RW, $clog2(ROWS) (min 1), row address width
- clk  in  1  single clock, rising edge
- reset  in  1  asynchronous, active-high
- s_rd_en  in  1  scalar read request
- s_wr_en  in  1  scalar write request
- s_addr  in  AW  scalar word address
- s_wdata  in  WORD_W  scalar write data
- s_rdata  out  WORD_W  scalar read data
- s_rvalid  out  1  scalar read data valid pulse
- s_err  out  1  scalar error pulse
- n_rd_en  in  1  NPU row read request
- n_wr_en  in  1  NPU row write request
- n_addr  in  RW  NPU row address
- n_wdata  in  LANES*WORD_W  row write data; lane k = bits [k*WORD_W +: WORD_W] = word n_addr*LANES+k
- n_rdata  out  LANES*WORD_W  row read data
- n_rvalid  out  1  NPU read data valid pulse
- n_err  out  1  NPU error pulse
- clr_start  in  1  start clear engine
- clr_busy  out  1  clear in progress
- clr_done  out  1  one-cycle pulse at clear completion

## Operation
- Reset (async): every array word = 0; all outputs 0; clear FSM = IDLE, row counter = 0.
- Clear FSM states IDLE, CLEAR, DONE.
  - IDLE: clr_start=1 -> CLEAR, counter=0.
  - CLEAR: writes zero to row counter; counter==ROWS-1 -> DONE, else counter+1. clr_busy=1.
  - DONE: clr_done=1 for one cycle -> IDLE.
  - clr_start in CLEAR/DONE ignored.
- Port requests accepted only in IDLE or DONE. Any request (rd or wr) during CLEAR is dropped, no array change; the port's err pulses next cycle (with rvalid if it was a read, rdata=0).
- Out of range: s_addr >= DEPTH or n_addr >= ROWS -> no write; read returns 0. err pulses next cycle; a read still produces rvalid.
- Simultaneous rd_en and wr_en on one port: both performed; read returns pre-write data (read-first).
- Cross-port read of a word written the same cycle returns old data.
- Scalar write and NPU write hitting the same word in the same cycle: NPU data wins for that word; the scalar write is discarded, no error. Other lanes unaffected.
- rdata holds its last value when no read is issued; cleared only by reset.

## Timing
- Read latency 1: request at edge N -> rdata/rvalid valid after edge N+1, rvalid high exactly one cycle per accepted or errored read.
- Write visible to reads issued on the next cycle.
- err is a one-cycle pulse, registered, aligned with the cycle rvalid would appear.
- Clear takes ROWS cycles in CLEAR + 1 cycle DONE; clr_busy high for exactly ROWS cycles after the clr_start edge.
- Ports may issue back-to-back every cycle; no backpressure.
- Reset mid-clear: array zeroed, FSM IDLE immediately, no clr_done.

## Structure
- Package npu_mem_pkg: clear-state enum (IDLE, CLEAR, DONE), default WORD_W/LANES/DEPTH constants, row/word index helper function (row, lane -> word).
- Sub-module npu_mem_clear_ctrl: clear FSM and row counter; outputs clear_we, clear_row, clr_busy, clr_done, port_block. Array, port logic and collision resolution stay in top.

## Test plan
- Reset then scalar read addr 5 -> s_rdata=0, s_rvalid one cycle later, s_err=0.
- Scalar write 0xABCDEF to addr 4; NPU read row 1 next cycle -> n_rdata lane1=0xABCDEF, lanes 0/2=0.
- NPU write row 2 {0x333333,0x222222,0x111111} plus scalar write 0x999999 to addr 7 same cycle -> addr 7 reads 0x222222; addr 6=0x111111, 8=0x333333.
- Scalar write addr 18 and NPU read row 6 (DEPTH=18) -> s_err and n_err pulse, n_rvalid=1, n_rdata=0, array unchanged.
- Fill array, pulse clr_start, issue scalar read during CLEAR -> s_err pulse, rdata=0; clr_busy high 6 cycles, clr_done 1 cycle; all words read 0 after.
- Assert reset at clear row 3 -> clr_busy drops immediately, no clr_done, all outputs 0, new clr_start runs full 6-row clear.
